// File: rtl/hazard_controller.sv
// Pipeline hazard controller: resolves memory stalls, taken branches and load-use
// hazards into per-stage freeze/flush/bubble controls, with stall and timeout tracking.
module hazard_controller #(
  parameter int TIMEOUT = 255,
  parameter bit FWD_EN  = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_uses_src2,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             id_exe_freeze,
  output logic             exe_mem_freeze,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  state_t           state_reg, state_next;
  logic [15:0]      wait_cnt_reg, wait_cnt_next;
  logic [16:0]      wait_inc;
  logic             timeout_hit;
  logic [CNT_W-1:0] stall_count_reg;
  logic             mem_timeout_reg;

  logic raw_exe, raw_mem, load_use, mem_stall;

  // Register 0 is hardwired zero, so a write to it never creates a dependency.
  assign raw_exe = exe_wb_en && (exe_dest != 5'd0) && id_valid &&
                   ((exe_dest == id_src1) || (id_uses_src2 && (exe_dest == id_src2)));
  assign raw_mem = mem_wb_en && (mem_dest != 5'd0) && id_valid &&
                   ((mem_dest == id_src1) || (id_uses_src2 && (mem_dest == id_src2)));
  assign load_use  = FWD_EN ? (raw_exe && exe_mem_read) : (raw_exe || raw_mem);
  assign mem_stall = mem_req && !mem_ready;

  always_comb begin
    state_next     = RUN;
    pc_freeze      = 1'b0;
    if_id_freeze   = 1'b0;
    id_exe_freeze  = 1'b0;
    exe_mem_freeze = 1'b0;
    if_id_flush    = 1'b0;
    id_exe_bubble  = 1'b0;
    if (mem_stall) begin
      pc_freeze      = 1'b1;
      if_id_freeze   = 1'b1;
      id_exe_freeze  = 1'b1;
      exe_mem_freeze = 1'b1;
      state_next     = MEM_WAIT;
    end else if (branch_taken) begin
      if_id_flush   = 1'b1;
      id_exe_bubble = 1'b1;
    end else if (load_use) begin
      pc_freeze     = 1'b1;
      if_id_freeze  = 1'b1;
      id_exe_bubble = 1'b1;
    end
    // Reset overrides everything, even in the middle of a memory wait.
    if (!rst) begin
      pc_freeze      = 1'b0;
      if_id_freeze   = 1'b0;
      id_exe_freeze  = 1'b0;
      exe_mem_freeze = 1'b0;
      if_id_flush    = 1'b0;
      id_exe_bubble  = 1'b0;
      state_next     = RUN;
    end
  end

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    wait_inc      = {1'b0, wait_cnt_reg} + 17'd1;
    timeout_hit   = 1'b0;
    if (state_reg == RUN && mem_stall) begin
      wait_cnt_next = 16'd0;
    end else if (state_reg == MEM_WAIT && mem_stall) begin
      if (wait_cnt_reg != 16'hFFFF) wait_cnt_next = wait_inc[15:0];
      timeout_hit = (wait_inc >= TIMEOUT_L);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= RUN;
      wait_cnt_reg    <= 16'd0;
      stall_count_reg <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (pc_freeze && stall_count_reg != {CNT_W{1'b1}})
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      if (timeout_hit) mem_timeout_reg <= 1'b1;
    end
  end

  assign stall_count = stall_count_reg;
  assign mem_timeout = mem_timeout_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a forwarding instance (TIMEOUT=3) and a
// no-forwarding instance share all stimulus; expectations are hand-computed.
module tb_hazard_controller;

  logic       clk, rst;
  logic       id_valid, id_uses_src2, exe_wb_en, exe_mem_read, mem_wb_en;
  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       branch_taken, mem_req, mem_ready;

  logic        pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze, if_id_flush, id_exe_bubble;
  logic [15:0] stall_count;
  logic        mem_timeout;

  logic        pc_freeze_nf, if_id_freeze_nf, id_exe_freeze_nf, exe_mem_freeze_nf, if_id_flush_nf, id_exe_bubble_nf;
  logic [15:0] stall_count_nf;
  logic        mem_timeout_nf;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_controller #(.TIMEOUT(3), .FWD_EN(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src2(id_uses_src2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .id_exe_freeze(id_exe_freeze),
    .exe_mem_freeze(exe_mem_freeze), .if_id_flush(if_id_flush), .id_exe_bubble(id_exe_bubble),
    .stall_count(stall_count), .mem_timeout(mem_timeout)
  );

  hazard_controller #(.FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_uses_src2(id_uses_src2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .exe_mem_read(exe_mem_read), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_freeze(pc_freeze_nf), .if_id_freeze(if_id_freeze_nf), .id_exe_freeze(id_exe_freeze_nf),
    .exe_mem_freeze(exe_mem_freeze_nf), .if_id_flush(if_id_flush_nf), .id_exe_bubble(id_exe_bubble_nf),
    .stall_count(stall_count_nf), .mem_timeout(mem_timeout_nf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_uses_src2 = 0; exe_wb_en = 0; exe_mem_read = 0; mem_wb_en = 0;
    id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    rst = 0; clear_inputs();
    mem_req = 1; mem_ready = 0; branch_taken = 1;
    step(); step();
    tests_run++; if (pc_freeze !== 1'b0) begin tests_failed++; $display("FAIL reset_pc_freeze got %b want 0", pc_freeze); end
    tests_run++; if (exe_mem_freeze !== 1'b0) begin tests_failed++; $display("FAIL reset_exe_mem_freeze got %b want 0", exe_mem_freeze); end
    tests_run++; if (if_id_flush !== 1'b0) begin tests_failed++; $display("FAIL reset_flush got %b want 0", if_id_flush); end
    tests_run++; if (stall_count !== 16'd0) begin tests_failed++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
    tests_run++; if (mem_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout got %b want 0", mem_timeout); end
    $display("[TB] reset done");
    clear_inputs(); rst = 1;
    step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; id_src1 = 3; exe_dest = 3; exe_wb_en = 1; exe_mem_read = 1;
    #1;
    tests_run++; if (pc_freeze !== 1'b1) begin tests_failed++; $display("FAIL lu_pc_freeze got %b want 1", pc_freeze); end
    tests_run++; if (if_id_freeze !== 1'b1) begin tests_failed++; $display("FAIL lu_if_id_freeze got %b want 1", if_id_freeze); end
    tests_run++; if (id_exe_bubble !== 1'b1) begin tests_failed++; $display("FAIL lu_bubble got %b want 1", id_exe_bubble); end
    tests_run++; if (id_exe_freeze !== 1'b0) begin tests_failed++; $display("FAIL lu_id_exe_freeze got %b want 0", id_exe_freeze); end
    tests_run++; if (if_id_flush !== 1'b0) begin tests_failed++; $display("FAIL lu_flush got %b want 0", if_id_flush); end
    step();
    // The load has moved to MEM; forwarding covers it, no-forwarding still stalls.
    clear_inputs();
    id_valid = 1; id_src1 = 3; mem_dest = 3; mem_wb_en = 1;
    #1;
    tests_run++; if (pc_freeze !== 1'b0) begin tests_failed++; $display("FAIL lu_second_cycle_pc_freeze got %b want 0", pc_freeze); end
    tests_run++; if (id_exe_bubble !== 1'b0) begin tests_failed++; $display("FAIL lu_second_cycle_bubble got %b want 0", id_exe_bubble); end
    tests_run++; if (pc_freeze_nf !== 1'b1) begin tests_failed++; $display("FAIL nf_mem_raw_pc_freeze got %b want 1", pc_freeze_nf); end
    tests_run++; if (stall_count !== 16'd1) begin tests_failed++; $display("FAIL lu_stall_count got %0d want 1", stall_count); end
    $display("[TB] load_use r3 stall_count=%0d", stall_count);
    clear_inputs();
    step();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    id_valid = 1; id_src1 = 0; exe_dest = 0; exe_wb_en = 1; exe_mem_read = 1;
    #1;
    tests_run++; if (pc_freeze !== 1'b0) begin tests_failed++; $display("FAIL r0_no_stall got %b want 0", pc_freeze); end
    tests_run++; if (pc_freeze_nf !== 1'b0) begin tests_failed++; $display("FAIL nf_r0_no_stall got %b want 0", pc_freeze_nf); end
    clear_inputs();
    id_valid = 1; id_src2 = 5; id_uses_src2 = 1; mem_dest = 5; mem_wb_en = 1;
    #1;
    tests_run++; if (pc_freeze !== 1'b0) begin tests_failed++; $display("FAIL fwd_alu_mem got %b want 0", pc_freeze); end
    tests_run++; if (pc_freeze_nf !== 1'b1) begin tests_failed++; $display("FAIL nf_alu_mem_src2 got %b want 1", pc_freeze_nf); end
    tests_run++; if (id_exe_bubble_nf !== 1'b1) begin tests_failed++; $display("FAIL nf_alu_mem_bubble got %b want 1", id_exe_bubble_nf); end
    id_uses_src2 = 0;
    #1;
    tests_run++; if (pc_freeze_nf !== 1'b0) begin tests_failed++; $display("FAIL nf_immediate_form got %b want 0", pc_freeze_nf); end
    clear_inputs();
    id_valid = 1; id_src2 = 9; id_uses_src2 = 1; exe_dest = 9; exe_wb_en = 1; exe_mem_read = 0;
    #1;
    tests_run++; if (pc_freeze !== 1'b0) begin tests_failed++; $display("FAIL fwd_alu_exe got %b want 0", pc_freeze); end
    tests_run++; if (pc_freeze_nf !== 1'b1) begin tests_failed++; $display("FAIL nf_alu_exe got %b want 1", pc_freeze_nf); end
    id_valid = 0; exe_mem_read = 1;
    #1;
    tests_run++; if (pc_freeze !== 1'b0) begin tests_failed++; $display("FAIL invalid_id_no_stall got %b want 0", pc_freeze); end
    $display("[TB] forwarding variants checked");
    clear_inputs();
    step();
  endtask

  task automatic test_branch();
    clear_inputs();
    id_valid = 1; id_src1 = 3; exe_dest = 3; exe_wb_en = 1; exe_mem_read = 1; branch_taken = 1;
    #1;
    tests_run++; if (if_id_flush !== 1'b1) begin tests_failed++; $display("FAIL br_flush got %b want 1", if_id_flush); end
    tests_run++; if (id_exe_bubble !== 1'b1) begin tests_failed++; $display("FAIL br_bubble got %b want 1", id_exe_bubble); end
    tests_run++; if (pc_freeze !== 1'b0) begin tests_failed++; $display("FAIL br_pc_freeze got %b want 0", pc_freeze); end
    tests_run++; if (if_id_freeze !== 1'b0) begin tests_failed++; $display("FAIL br_if_id_freeze got %b want 0", if_id_freeze); end
    step();
    clear_inputs();
    #1;
    tests_run++; if (stall_count !== 16'd1) begin tests_failed++; $display("FAIL br_stall_count got %0d want 1", stall_count); end
    $display("[TB] branch over load_use stall_count=%0d", stall_count);
    step();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    mem_req = 1; mem_ready = 0; branch_taken = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++; if (pc_freeze !== 1'b1) begin tests_failed++; $display("FAIL mw_pc_freeze[%0d] got %b want 1", i, pc_freeze); end
      tests_run++; if (exe_mem_freeze !== 1'b1) begin tests_failed++; $display("FAIL mw_exe_mem_freeze[%0d] got %b want 1", i, exe_mem_freeze); end
      tests_run++; if (if_id_flush !== 1'b0) begin tests_failed++; $display("FAIL mw_held_branch_flush[%0d] got %b want 0", i, if_id_flush); end
      tests_run++; if (mem_timeout !== 1'b0) begin tests_failed++; $display("FAIL mw_early_timeout[%0d] got %b want 0", i, mem_timeout); end
      step();
    end
    mem_ready = 1;
    #1;
    tests_run++; if (pc_freeze !== 1'b0) begin tests_failed++; $display("FAIL mw_release_pc_freeze got %b want 0", pc_freeze); end
    tests_run++; if (id_exe_freeze !== 1'b0) begin tests_failed++; $display("FAIL mw_release_id_exe_freeze got %b want 0", id_exe_freeze); end
    tests_run++; if (if_id_flush !== 1'b1) begin tests_failed++; $display("FAIL mw_release_branch_flush got %b want 1", if_id_flush); end
    tests_run++; if (mem_timeout !== 1'b1) begin tests_failed++; $display("FAIL mw_timeout_set got %b want 1", mem_timeout); end
    step();
    clear_inputs();
    #1;
    tests_run++; if (stall_count !== 16'd5) begin tests_failed++; $display("FAIL mw_stall_count got %0d want 5", stall_count); end
    tests_run++; if (mem_timeout !== 1'b1) begin tests_failed++; $display("FAIL mw_timeout_sticky got %b want 1", mem_timeout); end
    tests_run++; if (mem_timeout_nf !== 1'b0) begin tests_failed++; $display("FAIL nf_timeout_default got %b want 0", mem_timeout_nf); end
    $display("[TB] mem_wait 4 cycles stall_count=%0d timeout=%b", stall_count, mem_timeout);
    step();
  endtask

  task automatic test_mem_req_drop();
    clear_inputs();
    mem_req = 1; mem_ready = 0;
    step();
    mem_req = 0;
    #1;
    tests_run++; if (pc_freeze !== 1'b0) begin tests_failed++; $display("FAIL drop_pc_freeze got %b want 0", pc_freeze); end
    tests_run++; if (exe_mem_freeze !== 1'b0) begin tests_failed++; $display("FAIL drop_exe_mem_freeze got %b want 0", exe_mem_freeze); end
    step();
    tests_run++; if (stall_count !== 16'd6) begin tests_failed++; $display("FAIL drop_stall_count got %0d want 6", stall_count); end
    tests_run++; if (mem_timeout !== 1'b1) begin tests_failed++; $display("FAIL drop_timeout_sticky got %b want 1", mem_timeout); end
    $display("[TB] mem_req drop stall_count=%0d", stall_count);
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    id_valid = 1; id_src1 = 7; exe_dest = 7; exe_wb_en = 1; exe_mem_read = 1;
    #1;
    tests_run++; if (pc_freeze !== 1'b1) begin tests_failed++; $display("FAIL b2b_first got %b want 1", pc_freeze); end
    step();
    clear_inputs();
    id_valid = 1; id_src2 = 8; id_uses_src2 = 1; exe_dest = 8; exe_wb_en = 1; exe_mem_read = 1;
    mem_dest = 7; mem_wb_en = 1;
    #1;
    tests_run++; if (pc_freeze !== 1'b1) begin tests_failed++; $display("FAIL b2b_second got %b want 1", pc_freeze); end
    step();
    clear_inputs();
    step();
    tests_run++; if (stall_count !== 16'd8) begin tests_failed++; $display("FAIL b2b_stall_count got %0d want 8", stall_count); end
    $display("[TB] back_to_back load_use stall_count=%0d", stall_count);
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    mem_req = 1; mem_ready = 0;
    step(); step();
    tests_run++; if (pc_freeze !== 1'b1) begin tests_failed++; $display("FAIL rmw_waiting got %b want 1", pc_freeze); end
    rst = 0;
    #1;
    tests_run++; if (pc_freeze !== 1'b0) begin tests_failed++; $display("FAIL rmw_pc_freeze got %b want 0", pc_freeze); end
    tests_run++; if (id_exe_freeze !== 1'b0) begin tests_failed++; $display("FAIL rmw_id_exe_freeze got %b want 0", id_exe_freeze); end
    step();
    tests_run++; if (stall_count !== 16'd0) begin tests_failed++; $display("FAIL rmw_stall_count got %0d want 0", stall_count); end
    tests_run++; if (mem_timeout !== 1'b0) begin tests_failed++; $display("FAIL rmw_timeout got %b want 0", mem_timeout); end
    rst = 1; clear_inputs();
    step();
    tests_run++; if (stall_count !== 16'd0) begin tests_failed++; $display("FAIL rmw_after_release_count got %0d want 0", stall_count); end
    id_valid = 1; id_src1 = 4; exe_dest = 4; exe_wb_en = 1; exe_mem_read = 1;
    #1;
    tests_run++; if (pc_freeze !== 1'b1) begin tests_failed++; $display("FAIL rmw_resume_lu got %b want 1", pc_freeze); end
    step();
    clear_inputs();
    #1;
    tests_run++; if (stall_count !== 16'd1) begin tests_failed++; $display("FAIL rmw_resume_count got %0d want 1", stall_count); end
    $display("[TB] reset mid MEM_WAIT stall_count=%0d timeout=%b", stall_count, mem_timeout);
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_mem_wait();
    test_mem_req_drop();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter TIMEOUT, default 255: MEM_WAIT cycle count at which mem_timeout sets.
REQ-002 Parameter FWD_EN, default 1: 1 = forwarding present downstream, 0 = no forwarding.
REQ-003 Parameter CNT_W, default 16: width of stall_count.
REQ-004 clk  input  1  the single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_src1, id_src2  input  5 each  ID source register numbers.
REQ-008 id_uses_src2  input  1  id_src2 is a true operand (not an immediate form).
REQ-009 exe_dest  input  5  EXE destination register; exe_wb_en input 1 EXE writes back; exe_mem_read input 1 EXE is a load.
REQ-010 mem_dest  input  5  MEM destination register; mem_wb_en input 1 MEM writes back.
REQ-011 branch_taken  input  1  branch resolved taken in EXE this cycle.
REQ-012 mem_req  input  1  MEM stage has a data-memory access this cycle.
REQ-013 mem_ready  input  1  data memory completes the access this cycle.
REQ-014 pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze  output  1 each  hold that register.
REQ-015 if_id_flush  output  1  load NOP into IF/ID; id_exe_bubble output 1 load NOP into ID/EXE.
REQ-016 stall_count  output  CNT_W  saturating count of stalled cycles; mem_timeout output 1 sticky error.

Function
REQ-017 Two-state FSM: RUN, MEM_WAIT; state and counters registered, control outputs combinational from state and inputs.
REQ-018 raw_exe = exe_wb_en and exe_dest!=0 and id_valid and (exe_dest==id_src1 or (id_uses_src2 and exe_dest==id_src2)); raw_mem is the same with mem_dest/mem_wb_en.
REQ-019 load_use = raw_exe and exe_mem_read when FWD_EN=1; load_use = raw_exe or raw_mem when FWD_EN=0.
REQ-020 mem_stall = mem_req and not mem_ready, evaluated in either state.
REQ-021 Priority per cycle: mem_stall > branch_taken > load_use > none.
REQ-022 mem_stall: pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze = 1; if_id_flush, id_exe_bubble = 0; next state MEM_WAIT.
REQ-023 branch_taken (no mem_stall): if_id_flush = 1, id_exe_bubble = 1, all freezes 0; next state RUN; a coincident load_use is ignored.
REQ-024 load_use (no mem_stall, no branch): pc_freeze = 1, if_id_freeze = 1, id_exe_bubble = 1, other outputs 0; re-evaluated every cycle, so FWD_EN=1 gives exactly one bubble per load-use pair.
REQ-025 None of the above: all control outputs 0, next state RUN.
REQ-026 A branch_taken held during MEM_WAIT produces no flush until the first cycle with mem_ready=1, then flushes in that cycle per REQ-023.
REQ-027 wait_cnt (internal, 16 bits) clears on RUN->MEM_WAIT, increments each MEM_WAIT cycle with mem_stall, and saturates.
REQ-028 mem_timeout sets on the edge where wait_cnt reaches TIMEOUT and stays 1 until reset; it does not alter control outputs.
REQ-029 stall_count increments on every cycle with pc_freeze=1 and saturates at all ones.
REQ-030 mem_req=0 while in MEM_WAIT returns to RUN next edge with no freeze that cycle.

Reset
REQ-031 With rst=0 at a rising edge: state RUN, wait_cnt 0, stall_count 0, mem_timeout 0.
REQ-032 While rst=0 all control outputs are driven 0, including mid-MEM_WAIT; operation resumes in RUN on the first edge with rst=1.

Verification
REQ-033 Load r3 in EXE (exe_dest=3, exe_mem_read=1, exe_wb_en=1), ID src1=3 -> exactly one cycle of pc_freeze, if_id_freeze and id_exe_bubble; stall_count=1.
REQ-034 Same as REQ-033 but exe_dest=0 -> no stall; with FWD_EN=0 and ALU op mem_dest=5, id_src2=5, id_uses_src2=1 -> stall.
REQ-035 branch_taken=1 together with load_use -> if_id_flush=1, id_exe_bubble=1, pc_freeze=0.
REQ-036 mem_req=1, mem_ready=0 for 4 cycles, then 1 -> four cycles of all freezes, released in cycle 5; stall_count=4.
REQ-037 TIMEOUT=3, mem_ready held 0 -> mem_timeout=1 after wait_cnt reaches 3 and still 1 after mem_ready returns; cleared only by rst=0.
REQ-038 rst=0 asserted mid-MEM_WAIT -> outputs 0 immediately, state RUN, counters 0 after the edge.
